// File: rtl/core_seq_pkg.sv
// Shared types and constants for the core run sequencer.
package core_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HOLD,
    RUN,
    DONE
  } seq_state_t;

  localparam int unsigned HOLD_CYCLES         = 2;
  localparam logic [31:0] TOHOST_ADDR_DEFAULT = 32'h0000_0100;

endpackage

// File: rtl/seq_cycle_counter.sv
// 32-bit saturating RUN-cycle counter with clear/enable.
// With SEQ_TIMEOUT_EN defined it also flags the cycle whose increment reaches TIMEOUT.
module seq_cycle_counter
  import core_seq_pkg::*;
#(
  parameter logic [31:0] TIMEOUT = 32'd100000
) (
  input  logic        clk,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        en_i,
  output logic [31:0] count_o
`ifdef SEQ_TIMEOUT_EN
  ,
  output logic        limit_o
`endif
);

  logic [31:0] count_q;
  logic [31:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != 32'hFFFF_FFFF)) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

`ifdef SEQ_TIMEOUT_EN
  // Asserted in the cycle whose increment makes the count equal TIMEOUT.
  assign limit_o = en_i && (count_q == TIMEOUT - 32'd1);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

endmodule

// File: rtl/core_sequencer.sv
// Run controller: streams a program into IMEM, holds then releases the core, and
// reports the tohost result and cycle count. Optional run-cycle limit: SEQ_TIMEOUT_EN.
module core_sequencer
  import core_seq_pkg::*;
#(
  parameter int unsigned IMEM_WORDS  = 64,
  parameter logic [31:0] TOHOST_ADDR = TOHOST_ADDR_DEFAULT,
  parameter logic [31:0] TIMEOUT     = 32'd100000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          ld_valid,
  output logic                          ld_ready,
  input  logic [31:0]                   ld_data,
  input  logic                          ld_last,
  output logic                          imem_we,
  output logic [$clog2(IMEM_WORDS)-1:0] imem_addr,
  output logic [31:0]                   imem_wdata,
  output logic                          core_reset,
  input  logic                          core_memwrite,
  input  logic [31:0]                   core_dataadr,
  input  logic [31:0]                   core_writedata,
  output logic                          done,
  output logic                          pass,
  output logic                          timed_out,
  output logic [31:0]                   exit_code,
  output logic [31:0]                   cycles
);

  localparam int unsigned   AW        = $clog2(IMEM_WORDS);
  localparam logic [AW-1:0] LAST_ADDR = AW'(IMEM_WORDS - 1);

  seq_state_t  state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [1:0]  hold_q, hold_d;
  logic        core_reset_q, done_q;
  logic        pass_q, pass_d;
  logic        timed_out_q, timed_out_d;
  logic [31:0] exit_code_q, exit_code_d;
  logic        accept, tohost_hit, cnt_clr, cnt_en, limit;

  assign ld_ready   = (state_q == LOAD);
  assign accept     = ld_valid && ld_ready;
  assign imem_we    = accept;
  assign imem_addr  = addr_q;
  assign imem_wdata = ld_data;
  assign tohost_hit = core_memwrite && (core_dataadr == TOHOST_ADDR);
  assign cnt_en     = (state_q == RUN);

  seq_cycle_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_cycle_counter (
    .clk     (clk),
    .rst_ni  (reset),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .count_o (cycles)
`ifdef SEQ_TIMEOUT_EN
    ,
    .limit_o (limit)
`endif
  );

`ifndef SEQ_TIMEOUT_EN
  assign limit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    hold_d      = hold_q;
    pass_d      = pass_q;
    timed_out_d = timed_out_q;
    exit_code_d = exit_code_q;
    cnt_clr     = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = LOAD;
          addr_d      = '0;
          cnt_clr     = 1'b1;
          pass_d      = 1'b0;
          timed_out_d = 1'b0;
          exit_code_d = '0;
        end
      end
      LOAD: begin
        if (accept) begin
          addr_d = addr_q + 1'b1;
          // The top word fills the memory, so it ends the load even without ld_last.
          if (ld_last || (addr_q == LAST_ADDR)) begin
            state_d = HOLD;
            hold_d  = '0;
          end
        end
      end
      HOLD: begin
        if (hold_q == 2'(HOLD_CYCLES - 1)) begin
          state_d = RUN;
        end else begin
          hold_d = hold_q + 2'd1;
        end
      end
      RUN: begin
        // A tohost store in the limit cycle takes priority over the timeout.
        if (tohost_hit) begin
          state_d     = DONE;
          exit_code_d = core_writedata;
          pass_d      = (core_writedata == 32'd1);
        end else if (limit) begin
          state_d     = DONE;
          timed_out_d = 1'b1;
          pass_d      = 1'b0;
          exit_code_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      hold_q       <= '0;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      timed_out_q  <= 1'b0;
      exit_code_q  <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      hold_q       <= hold_d;
      core_reset_q <= (state_d != RUN);
      done_q       <= (state_d == DONE);
      pass_q       <= pass_d;
      timed_out_q  <= timed_out_d;
      exit_code_q  <= exit_code_d;
    end
  end

  assign core_reset = core_reset_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign timed_out  = timed_out_q;
  assign exit_code  = exit_code_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: random program loads and runs checked
// against expectations derived from the load/hold/run rules.
module tb_core_sequencer;

  localparam logic [31:0] TOHOST = 32'h0000_0100;
  localparam int          TMO    = 50;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start, ld_valid, ld_last, core_memwrite;
  logic [31:0] ld_data, core_dataadr, core_writedata;
  logic        ld_ready, imem_we, core_reset, done, pass, timed_out;
  logic [5:0]  imem_addr;
  logic [31:0] imem_wdata, exit_code, cycles;

  logic        s4_start, s4_valid, s4_last, s4_memwrite;
  logic [31:0] s4_data, s4_dataadr, s4_writedata;
  logic        s4_ld_ready, s4_imem_we, s4_core_reset, s4_done, s4_pass, s4_timed_out;
  logic [1:0]  s4_imem_addr;
  logic [31:0] s4_imem_wdata, s4_exit_code, s4_cycles;

  int checks   = 0;
  int failures = 0;

  logic [31:0] prog[$];
  logic [31:0] cap_mem[64];
  int          cap_cnt;

  core_sequencer #(.IMEM_WORDS(64), .TOHOST_ADDR(TOHOST), .TIMEOUT(32'(TMO))) dut (
    .clk(clk), .reset(reset), .start(start), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .ld_last(ld_last), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .core_reset(core_reset), .core_memwrite(core_memwrite),
    .core_dataadr(core_dataadr), .core_writedata(core_writedata), .done(done),
    .pass(pass), .timed_out(timed_out), .exit_code(exit_code), .cycles(cycles)
  );

  core_sequencer #(.IMEM_WORDS(4), .TOHOST_ADDR(TOHOST), .TIMEOUT(32'(TMO))) dut4 (
    .clk(clk), .reset(reset), .start(s4_start), .ld_valid(s4_valid), .ld_ready(s4_ld_ready),
    .ld_data(s4_data), .ld_last(s4_last), .imem_we(s4_imem_we), .imem_addr(s4_imem_addr),
    .imem_wdata(s4_imem_wdata), .core_reset(s4_core_reset), .core_memwrite(s4_memwrite),
    .core_dataadr(s4_dataadr), .core_writedata(s4_writedata), .done(s4_done),
    .pass(s4_pass), .timed_out(s4_timed_out), .exit_code(s4_exit_code), .cycles(s4_cycles)
  );

  // Memory image as seen by IMEM; sampled mid-cycle, well after input changes.
  always @(negedge clk) begin
    #2;
    if (imem_we === 1'b1) begin
      cap_mem[imem_addr] = imem_wdata;
      cap_cnt++;
    end
  end

  task automatic test_reset();
    reset = 1'b0;
    start = 0; ld_valid = 0; ld_last = 0; ld_data = '0;
    core_memwrite = 0; core_dataadr = '0; core_writedata = '0;
    s4_start = 0; s4_valid = 0; s4_last = 0; s4_data = '0;
    s4_memwrite = 0; s4_dataadr = '0; s4_writedata = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({core_reset, ld_ready, imem_we, imem_addr, done, pass, timed_out, exit_code, cycles}
        !== {1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0}) begin
      failures++;
      $display("FAIL reset_state: got core_reset=%b ld_ready=%b we=%b addr=%0d done=%b pass=%b to=%b exit=%h cyc=%0d, want 1 0 0 0 0 0 0 0 0",
               core_reset, ld_ready, imem_we, imem_addr, done, pass, timed_out, exit_code, cycles);
    end
    reset = 1'b1;
    @(negedge clk);
    ld_valid = 1'b1;
    #1;
    checks++;
    if ({ld_ready, imem_we, core_reset} !== 3'b001) begin
      failures++;
      $display("FAIL idle_no_accept: got ready=%b we=%b core_reset=%b, want 0 0 1", ld_ready, imem_we, core_reset);
    end
    ld_valid = 1'b0;
    @(negedge clk);
    $display("test_reset done");
  endtask

  // Two HOLD cycles follow the final accepted word, then core_reset drops.
  task automatic check_hold();
    for (int h = 0; h < 2; h++) begin
      ld_valid = 1'b1; ld_data = $urandom;
      #1;
      checks++;
      if ({core_reset, ld_ready, imem_we} !== 3'b100) begin
        failures++;
        $display("FAIL hold_cycle%0d: got core_reset=%b ready=%b we=%b, want 1 0 0", h, core_reset, ld_ready, imem_we);
      end
      @(negedge clk);
    end
    ld_valid = 1'b0;
    checks++;
    if ({core_reset, done, cycles} !== {1'b0, 1'b0, 32'd0}) begin
      failures++;
      $display("FAIL run_entry: got core_reset=%b done=%b cycles=%0d, want 0 0 0", core_reset, done, cycles);
    end
  endtask

  // mode 0: no stalls, 1: one idle cycle between words, 2: random stalls.
  task automatic load_prog(input int n, input int mode, input bit use_last);
    logic [31:0] w;
    int stall;
    prog.delete();
    cap_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({ld_ready, done, pass, timed_out, exit_code, cycles, core_reset}
        !== {1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1}) begin
      failures++;
      $display("FAIL load_entry: got ready=%b done=%b pass=%b to=%b exit=%h cyc=%0d core_reset=%b, want 1 0 0 0 0 0 1",
               ld_ready, done, pass, timed_out, exit_code, cycles, core_reset);
    end
    for (int i = 0; i < n; i++) begin
      stall = (mode == 1 && i > 0) ? 1 : (mode == 2 ? int'($urandom_range(0, 2)) : 0);
      repeat (stall) begin
        ld_valid = 1'b0; ld_data = $urandom; ld_last = 1'($urandom_range(0, 1));
        #1;
        checks++;
        if ({imem_we, ld_ready} !== 2'b01) begin
          failures++;
          $display("FAIL load_stall: got we=%b ready=%b, want 0 1", imem_we, ld_ready);
        end
        @(negedge clk);
      end
      w = $urandom;
      prog.push_back(w);
      ld_valid = 1'b1; ld_data = w; ld_last = use_last && (i == n - 1);
      #1;
      checks++;
      if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 6'(i), w}) begin
        failures++;
        $display("FAIL load_word%0d: got we=%b addr=%0d data=%h, want 1 %0d %h", i, imem_we, imem_addr, imem_wdata, i, w);
      end
      @(negedge clk);
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    checks++;
    if (cap_cnt != n) begin
      failures++;
      $display("FAIL load_count: got %0d writes, want %0d", cap_cnt, n);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (cap_mem[i] !== prog[i]) begin
        failures++;
        $display("FAIL imem_image[%0d]: got %h, want %h", i, cap_mem[i], prog[i]);
      end
    end
    check_hold();
    $display("load n=%0d mode=%0d last=%0d", n, mode, use_last);
  endtask

  // Drives RUN cycles first..last; cycles must read c-1 during cycle c.
  task automatic run_cycles(input int first, input int last, input bit do_store, input logic [31:0] val);
    for (int c = first; c <= last; c++) begin
      checks++;
      if ({done, core_reset, cycles} !== {1'b0, 1'b0, 32'(c - 1)}) begin
        failures++;
        $display("FAIL run_cycle%0d: got done=%b core_reset=%b cycles=%0d, want 0 0 %0d", c, done, core_reset, cycles, c - 1);
      end
      core_memwrite = 1'b0; core_dataadr = $urandom; core_writedata = $urandom; start = 1'b0;
      if (do_store && c == last) begin
        core_memwrite = 1'b1; core_dataadr = TOHOST; core_writedata = val;
      end else if (c == first) begin
        core_memwrite = 1'b1; core_dataadr = TOHOST + 32'd4;
      end else begin
        case ($urandom_range(0, 3))
          0: begin core_memwrite = 1'b1; core_dataadr = TOHOST + 32'd4; end
          1: begin core_memwrite = 1'b0; core_dataadr = TOHOST; end
          2: begin core_memwrite = 1'b1; if (core_dataadr == TOHOST) core_dataadr = core_dataadr ^ 32'd1; end
          default: ;
        endcase
      end
      if (c == first + 2) start = 1'b1;
      @(negedge clk);
    end
    core_memwrite = 1'b0; start = 1'b0;
  endtask

  task automatic check_store_done(input int k, input logic [31:0] val);
    logic exp_pass;
    exp_pass = (val == 32'd1);
    for (int r = 0; r < 2; r++) begin
      checks++;
      if ({done, pass, timed_out, core_reset, exit_code, cycles} !== {1'b1, exp_pass, 1'b0, 1'b1, val, 32'(k)}) begin
        failures++;
        $display("FAIL store_done%0d: got done=%b pass=%b to=%b core_reset=%b exit=%h cyc=%0d, want 1 %b 0 1 %h %0d",
                 r, done, pass, timed_out, core_reset, exit_code, cycles, exp_pass, val, k);
      end
      @(negedge clk);
    end
    $display("run store at cycle %0d value %h", k, val);
  endtask

  task automatic test_basic_load();
    load_prog(3, 0, 1'b1);
    run_cycles(1, 10, 1'b1, 32'd1);
    check_store_done(10, 32'd1);
  endtask

  task automatic test_toggle_load();
    load_prog(4, 1, 1'b1);
    run_cycles(1, 6, 1'b1, 32'd7);
    check_store_done(6, 32'd7);
  endtask

  task automatic test_random_runs();
    int k;
    logic [31:0] v;
    for (int t = 0; t < 5; t++) begin
      k = $urandom_range(1, 40);
      v = ($urandom_range(0, 1) == 0) ? 32'd1 : $urandom;
      load_prog($urandom_range(1, 8), 2, 1'b1);
      run_cycles(1, k, 1'b1, v);
      check_store_done(k, v);
    end
  endtask

  task automatic test_full_depth();
    load_prog(64, 2, 1'b0);
    run_cycles(1, 3, 1'b1, 32'd1);
    check_store_done(3, 32'd1);
  endtask

  task automatic test_depth_limit();
    logic exp_acc;
    s4_start = 1'b1;
    @(negedge clk);
    s4_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      s4_valid = 1'b1; s4_data = $urandom; s4_last = 1'b0;
      #1;
      exp_acc = (i < 4);
      checks++;
      if ({s4_imem_we, s4_ld_ready, s4_core_reset} !== {exp_acc, exp_acc, 1'b1} ||
          (exp_acc && s4_imem_addr !== 2'(i))) begin
        failures++;
        $display("FAIL depth4_word%0d: got we=%b ready=%b addr=%0d core_reset=%b, want %b %b %0d 1",
                 i, s4_imem_we, s4_ld_ready, s4_imem_addr, s4_core_reset, exp_acc, exp_acc, i);
      end
      @(negedge clk);
    end
    s4_valid = 1'b0;
    checks++;
    if ({s4_core_reset, s4_ld_ready} !== 2'b00) begin
      failures++;
      $display("FAIL depth4_run: got core_reset=%b ready=%b, want 0 0", s4_core_reset, s4_ld_ready);
    end
    $display("depth limit: 6 words offered to 4-word memory");
  endtask

  task automatic test_mid_load_reset();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ld_valid = 1'b1;
    repeat (2) begin ld_data = $urandom; @(negedge clk); end
    reset = 1'b0;
    #1;
    checks++;
    if ({imem_addr, ld_ready, imem_we, core_reset} !== {6'd0, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL mid_load_reset: got addr=%0d ready=%b we=%b core_reset=%b, want 0 0 0 1", imem_addr, ld_ready, imem_we, core_reset);
    end
    @(negedge clk);
    reset = 1'b1; ld_valid = 1'b0;
    @(negedge clk);
    load_prog(3, 2, 1'b1);
    run_cycles(1, 2, 1'b1, 32'd2);
    check_store_done(2, 32'd2);
  endtask

  task automatic test_mid_run_reset();
    load_prog(2, 0, 1'b1);
    run_cycles(1, 5, 1'b0, 32'd0);
    reset = 1'b0;
    #1;
    checks++;
    if ({core_reset, ld_ready, imem_we, imem_addr, done, pass, timed_out, exit_code, cycles}
        !== {1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0}) begin
      failures++;
      $display("FAIL mid_run_reset: got core_reset=%b ready=%b we=%b addr=%0d done=%b pass=%b to=%b exit=%h cyc=%0d, want 1 0 0 0 0 0 0 0 0",
               core_reset, ld_ready, imem_we, imem_addr, done, pass, timed_out, exit_code, cycles);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({core_reset, ld_ready, cycles} !== {1'b1, 1'b0, 32'd0}) begin
      failures++;
      $display("FAIL after_reset_idle: got core_reset=%b ready=%b cyc=%0d, want 1 0 0", core_reset, ld_ready, cycles);
    end
    $display("mid-run reset");
  endtask

  task automatic test_cycle_limit();
`ifdef SEQ_TIMEOUT_EN
    load_prog(2, 0, 1'b1);
    run_cycles(1, TMO, 1'b0, 32'd0);
    checks++;
    if ({done, timed_out, pass, core_reset, exit_code, cycles} !== {1'b1, 1'b1, 1'b0, 1'b1, 32'd0, 32'(TMO)}) begin
      failures++;
      $display("FAIL timeout: got done=%b to=%b pass=%b core_reset=%b exit=%h cyc=%0d, want 1 1 0 1 0 %0d",
               done, timed_out, pass, core_reset, exit_code, cycles, TMO);
    end
    load_prog(2, 0, 1'b1);
    run_cycles(1, TMO, 1'b1, 32'd1);
    check_store_done(TMO, 32'd1);
`else
    load_prog(2, 0, 1'b1);
    run_cycles(1, TMO + 10, 1'b0, 32'd0);
    checks++;
    if ({done, timed_out, core_reset, cycles} !== {1'b0, 1'b0, 1'b0, 32'(TMO + 10)}) begin
      failures++;
      $display("FAIL no_limit: got done=%b to=%b core_reset=%b cyc=%0d, want 0 0 0 %0d",
               done, timed_out, core_reset, cycles, TMO + 10);
    end
`endif
    $display("cycle limit scenario");
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_toggle_load();
    test_random_runs();
    test_full_depth();
    test_depth_limit();
    test_mid_load_reset();
    test_mid_run_reset();
    test_cycle_limit();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
